// File: rtl/cpu_dbus_pkg.sv
// Shared data-bus definitions: region decode constants, bridge state encodings and the
// address decoder, kept here so the instruction-side bridge can reuse them.
package cpu_dbus_pkg;

  localparam logic [3:0]  IO_REGION_DEFAULT = 4'hE;
  localparam logic [31:0] RAM_BASE          = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRamAck = 2'd1,
    StIoWait = 2'd2,
    StErrAck = 2'd3
  } bus_state_e;

  typedef enum logic [1:0] {
    RegionRam  = 2'd0,
    RegionIo   = 2'd1,
    RegionNone = 2'd2
  } region_e;

  // RAM wins if it ever grows far enough to overlap the I/O nibble.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned ram_addr_bits,
                                            input logic [3:0]  io_region);
    logic [31:0] ram_hi;
    ram_hi = (addr - RAM_BASE) >> (ram_addr_bits + 2);
    if (ram_hi == '0) begin
      return RegionRam;
    end else if (addr[31:28] == io_region) begin
      return RegionIo;
    end
    return RegionNone;
  endfunction

endpackage

// File: rtl/cpu_dbus.sv
// Data-side bridge: routes single-cycle CPU requests to block RAM, the I/O bus or an
// error completion, and returns ack/read data without any combinational path from cpu_*.
module cpu_dbus
  import cpu_dbus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS  = 14,
  parameter logic [3:0]  IO_REGION      = IO_REGION_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_request,
  input  logic [31:0]              cpu_address,
  input  logic                     cpu_write,
  input  logic [3:0]               cpu_wstrb,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_ack,
  output logic                     ram_en,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [3:0]               ram_wstrb,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata,
  output logic                     io_request,
  output logic [31:0]              io_address,
  output logic                     io_write,
  output logic [3:0]               io_wstrb,
  output logic [31:0]              io_wdata,
  input  logic [31:0]              io_rdata,
  input  logic                     io_ack,
  output logic                     bus_error,
  output logic [31:0]              bus_error_addr
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  bus_state_e  state_q;
  logic [15:0] count_q;
  logic        timeout_hit;
  logic        accept;
  region_e     region;

  // Completion side: only state, RAM data and the I/O handshake feed these.
  always_comb begin
    timeout_hit = (state_q == StIoWait) && !io_ack && (count_q == TimeoutLast);
    cpu_ack     = 1'b0;
    cpu_rdata   = '0;
    bus_error   = 1'b0;
    unique case (state_q)
      StRamAck: begin
        cpu_ack   = 1'b1;
        cpu_rdata = ram_rdata;
      end
      StIoWait: begin
        cpu_ack   = io_ack | timeout_hit;
        cpu_rdata = io_ack ? io_rdata : '0;
        bus_error = timeout_hit;
      end
      StErrAck: begin
        cpu_ack   = 1'b1;
        bus_error = 1'b1;
      end
      default: ;
    endcase
  end

  // Requests arriving while busy and not acking are dropped, including their RAM strobe.
  always_comb begin
    region    = decode_region(cpu_address, RAM_ADDR_BITS, IO_REGION);
    accept    = cpu_request && ((state_q == StIdle) || cpu_ack);
    ram_en    = accept && (region == RegionRam);
    ram_addr  = cpu_address[RAM_ADDR_BITS+1:2];
    ram_wstrb = cpu_write ? cpu_wstrb : 4'b0000;
    ram_wdata = cpu_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= '0;
      io_request     <= 1'b0;
      io_address     <= '0;
      io_write       <= 1'b0;
      io_wstrb       <= '0;
      io_wdata       <= '0;
      bus_error_addr <= '0;
    end else begin
      if (timeout_hit) begin
        bus_error_addr <= io_address;
      end
      if ((state_q == StIoWait) && !io_ack && !timeout_hit) begin
        count_q <= count_q + 16'd1;
      end
      if (accept) begin
        unique case (region)
          RegionRam: begin
            state_q    <= StRamAck;
            io_request <= 1'b0;
          end
          RegionIo: begin
            state_q    <= StIoWait;
            io_request <= 1'b1;
            io_address <= cpu_address;
            io_write   <= cpu_write;
            io_wstrb   <= cpu_wstrb;
            io_wdata   <= cpu_wdata;
            count_q    <= '0;
          end
          default: begin
            state_q        <= StErrAck;
            io_request     <= 1'b0;
            bus_error_addr <= cpu_address;
          end
        endcase
      end else if (cpu_ack) begin
        state_q    <= StIdle;
        io_request <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dbus.sv
// Directed bench for cpu_dbus: a vector table for the RAM/unmapped paths plus hand
// sequences for I/O handshake, timeout, protocol violation and mid-transaction reset.
module tb_cpu_dbus;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_request;
  logic [31:0] cpu_address;
  logic        cpu_write;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        ram_en;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_request;
  logic [31:0] io_address;
  logic        io_write;
  logic [3:0]  io_wstrb;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic        bus_error;
  logic [31:0] bus_error_addr;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  cpu_dbus #(
    .RAM_ADDR_BITS (14),
    .IO_REGION     (4'hE),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_request   (cpu_request),
    .cpu_address   (cpu_address),
    .cpu_write     (cpu_write),
    .cpu_wstrb     (cpu_wstrb),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .ram_en        (ram_en),
    .ram_addr      (ram_addr),
    .ram_wstrb     (ram_wstrb),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .io_request    (io_request),
    .io_address    (io_address),
    .io_write      (io_write),
    .io_wstrb      (io_wstrb),
    .io_wdata      (io_wdata),
    .io_rdata      (io_rdata),
    .io_ack        (io_ack),
    .bus_error     (bus_error),
    .bus_error_addr(bus_error_addr)
  );

  // Block RAM model: byte-enabled write, 1-cycle registered read.
  logic [31:0] mem [0:(1<<14)-1];
  always @(posedge clock) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wstrb[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_ram_en;
    logic [13:0] e_ram_addr;
    logic        e_ack;
    logic        e_err;
    logic        chk_rdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic req, input logic wr, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic e_ram_en, input logic [13:0] e_ram_addr,
                              input logic e_ack, input logic e_err, input logic chk_rdata,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.req = req; v.wr = wr; v.strb = strb; v.addr = addr; v.wdata = wdata;
    v.e_ram_en = e_ram_en; v.e_ram_addr = e_ram_addr; v.e_ack = e_ack; v.e_err = e_err;
    v.chk_rdata = chk_rdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic drive(input logic req, input logic wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    cpu_request = req;
    cpu_write   = wr;
    cpu_wstrb   = strb;
    cpu_address = addr;
    cpu_wdata   = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    vecs[0]  = mk(1, 1, 4'hF, 32'h10, 32'h12345678, 1, 14'd4, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 4'h0, 32'h10, 32'h0,        1, 14'd4, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 1, 0, 1, 32'h12345678);
    vecs[3]  = mk(1, 1, 4'hF, 32'h0,  32'h11111111, 1, 14'd0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 4'hF, 32'h4,  32'h22222222, 1, 14'd1, 1, 0, 0, 0);
    vecs[5]  = mk(1, 1, 4'hF, 32'h8,  32'h33333333, 1, 14'd2, 1, 0, 0, 0);
    vecs[6]  = mk(1, 0, 4'h0, 32'h0,  32'h0,        1, 14'd0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 4'h0, 32'h4,  32'h0,        1, 14'd1, 1, 0, 1, 32'h11111111);
    vecs[8]  = mk(1, 0, 4'h0, 32'h8,  32'h0,        1, 14'd2, 1, 0, 1, 32'h22222222);
    vecs[9]  = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 1, 0, 1, 32'h33333333);
    vecs[10] = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 0, 0, 0, 0);
    vecs[11] = mk(1, 1, 4'h5, 32'h8,  32'hAABBCCDD, 1, 14'd2, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 4'h0, 32'h8,  32'h0,        1, 14'd2, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 1, 0, 1, 32'h33BB33DD);
    vecs[14] = mk(1, 1, 4'hF, 32'h80000000, 32'hDEADBEEF, 0, 14'd0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 1, 1, 1, 32'h0);
    vecs[16] = mk(1, 0, 4'h0, 32'h00010000, 32'h0,  0, 14'd0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 1, 1, 1, 32'h0);
    vecs[18] = mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 0, 0, 0, 0);

    reset = 1'b1;
    io_ack = 1'b0;
    io_rdata = '0;
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk1("reset cpu_ack", cpu_ack, 1'b0);
    chk1("reset bus_error", bus_error, 1'b0);
    chk1("reset io_request", io_request, 1'b0);
    check("reset bus_error_addr", bus_error_addr, 32'h0);
    check("reset io_address", io_address, 32'h0);

    // RAM and unmapped paths, one vector per cycle.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req, vecs[i].wr, vecs[i].strb, vecs[i].addr, vecs[i].wdata);
      #1;
      chk1($sformatf("v%0d ram_en", i), ram_en, vecs[i].e_ram_en);
      if (vecs[i].e_ram_en) begin
        check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_ram_addr));
        check($sformatf("v%0d ram_wstrb", i), 32'(ram_wstrb),
              32'(vecs[i].wr ? vecs[i].strb : 4'h0));
      end
      chk1($sformatf("v%0d cpu_ack", i), cpu_ack, vecs[i].e_ack);
      chk1($sformatf("v%0d bus_error", i), bus_error, vecs[i].e_err);
      chk1($sformatf("v%0d io_request", i), io_request, 1'b0);
      if (vecs[i].chk_rdata) check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
      @(negedge clock);
    end
    check("unmapped bus_error_addr", bus_error_addr, 32'h00010000);

    // I/O read acked after 3 wait cycles, with a protocol-violating request mid-wait.
    drive(1, 0, 4'h0, 32'hE0000004, 32'h0);
    #1;
    chk1("io req ram_en", ram_en, 1'b0);
    @(negedge clock);
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk1("io w1 io_request", io_request, 1'b1);
    check("io w1 io_address", io_address, 32'hE0000004);
    chk1("io w1 io_write", io_write, 1'b0);
    chk1("io w1 cpu_ack", cpu_ack, 1'b0);
    @(negedge clock);
    drive(1, 1, 4'hF, 32'h0, 32'hFFFFFFFF);
    #1;
    chk1("violation ram_en", ram_en, 1'b0);
    chk1("io w2 cpu_ack", cpu_ack, 1'b0);
    @(negedge clock);
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk1("io w3 io_request", io_request, 1'b1);
    check("io w3 io_address", io_address, 32'hE0000004);
    chk1("io w3 cpu_ack", cpu_ack, 1'b0);
    @(negedge clock);
    io_ack = 1'b1;
    io_rdata = 32'hCAFEF00D;
    drive(1, 1, 4'h3, 32'hE0000100, 32'h5A5A5A5A);
    #1;
    chk1("io ack cpu_ack", cpu_ack, 1'b1);
    check("io ack cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    chk1("io ack bus_error", bus_error, 1'b0);
    chk1("io ack io_request", io_request, 1'b1);
    @(negedge clock);

    // Re-armed I/O write with no ack: error completion on the 8th wait cycle.
    io_ack = 1'b0;
    io_rdata = 32'hFFFFFFFF;
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk1($sformatf("to w%0d cpu_ack", i), cpu_ack, i == 8);
      chk1($sformatf("to w%0d bus_error", i), bus_error, i == 8);
      if (i == 1) begin
        chk1("to io_request", io_request, 1'b1);
        check("to io_address", io_address, 32'hE0000100);
        chk1("to io_write", io_write, 1'b1);
        check("to io_wstrb", 32'(io_wstrb), 32'h3);
        check("to io_wdata", io_wdata, 32'h5A5A5A5A);
      end
      if (i == 8) check("to cpu_rdata", cpu_rdata, 32'h0);
      @(negedge clock);
    end
    #1;
    chk1("to after io_request", io_request, 1'b0);
    chk1("to after cpu_ack", cpu_ack, 1'b0);
    check("to bus_error_addr", bus_error_addr, 32'hE0000100);
    io_ack = 1'b1;
    #1;
    chk1("late ack cpu_ack", cpu_ack, 1'b0);
    chk1("late ack bus_error", bus_error, 1'b0);
    @(negedge clock);
    io_ack = 1'b0;
    #1;
    chk1("late ack io_request", io_request, 1'b0);

    // Reset during I/O wait aborts silently; RAM traffic then resumes.
    drive(1, 0, 4'h0, 32'hE0000008, 32'h0);
    @(negedge clock);
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk1("rst pre io_request", io_request, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk1("rst io_request", io_request, 1'b0);
    chk1("rst cpu_ack", cpu_ack, 1'b0);
    check("rst bus_error_addr", bus_error_addr, 32'h0);
    io_ack = 1'b1;
    #1;
    chk1("rst stray ack cpu_ack", cpu_ack, 1'b0);
    @(negedge clock);
    io_ack = 1'b0;
    drive(1, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk1("post rst ram_en", ram_en, 1'b1);
    @(negedge clock);
    drive(1, 0, 4'h0, 32'h10, 32'h0);
    #1;
    chk1("post rst ack0", cpu_ack, 1'b1);
    check("post rst rdata0", cpu_rdata, 32'h11111111);
    @(negedge clock);
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk1("post rst ack1", cpu_ack, 1'b1);
    check("post rst rdata1", cpu_rdata, 32'h12345678);
    @(negedge clock);
    #1;
    chk1("post rst idle ack", cpu_ack, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_dbus.md
Name: cpu_dbus

Overview:
Data-side bus bridge directly downstream of the ALU/memory stage. It accepts the single-cycle CPU memory request, decodes the address, and routes it to one of two targets: on-chip block RAM with fixed 1-cycle read latency, or the peripheral I/O bus with variable latency and a request/ack handshake. It returns read data and an ack to the stage-4 writeback/stall logic. Unmapped addresses and I/O timeouts are completed with a bus-error pulse so the pipeline never hangs.

Parameters:
RAM_ADDR_BITS, 14, word-address width of on-chip RAM (64 KB); RAM occupies 0x00000000 up to (4<<RAM_ADDR_BITS)-1
IO_REGION, 4'hE, value of cpu_address[31:28] that selects the I/O bus
TIMEOUT_CYCLES, 255, max cycles io_request stays high without io_ack before forced error completion (range 1..65535)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cpu_request  in  1  single-cycle request strobe from the CPU
cpu_address  in  32  byte address
cpu_write  in  1  1 = write
cpu_wstrb  in  4  byte enables (writes only)
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid when cpu_ack=1
cpu_ack  out  1  transaction complete
ram_en  out  1  RAM access enable
ram_addr  out  RAM_ADDR_BITS  RAM word address
ram_wstrb  out  4  RAM byte write enables (0 for reads)
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en
io_request  out  1  I/O request, held until io_ack
io_address  out  32  latched address
io_write  out  1  latched write flag
io_wstrb  out  4  latched strobes
io_wdata  out  32  latched write data
io_rdata  in  32  I/O read data, valid with io_ack
io_ack  in  1  I/O completion
bus_error  out  1  one-cycle pulse, coincident with the erroring cpu_ack
bus_error_addr  out  32  address of the most recent errored access

Behaviour:
- Decode: RAM if cpu_address[31:RAM_ADDR_BITS+2]==0; IO if cpu_address[31:28]==IO_REGION; else UNMAPPED.
- States: IDLE, RAM_ACK, IO_WAIT, ERR_ACK. Reset -> IDLE; io_request=0, bus_error=0, bus_error_addr=0, timeout counter=0. Registered io_* data outputs reset to 0.
- RAM path (combinational, cycle T): ram_en=cpu_request&&RAM; ram_addr=cpu_address[RAM_ADDR_BITS+1:2]; ram_wstrb=cpu_write?cpu_wstrb:0; ram_wdata=cpu_wdata. Next state RAM_ACK. In T+1: cpu_ack=1, cpu_rdata=ram_rdata. RAM writes commit at the T edge.
- IO path: at the T edge, latch address/write/wstrb/wdata and set io_request=1, counter=0, state IO_WAIT. In IO_WAIT: cpu_ack=io_ack, cpu_rdata=io_rdata (combinational pass-through). The cycle io_ack=1 ends the transaction: io_request drops at that edge, or is re-armed if a new IO request arrives in the same cycle.
- Timeout: counter increments each IO_WAIT cycle without io_ack. When counter==TIMEOUT_CYCLES-1 and io_ack=0, that cycle asserts cpu_ack=1, cpu_rdata=0 and bus_error=1, and io_request drops. A late io_ack arriving in IDLE is ignored.
- UNMAPPED: no ram_en and no io_request; next state ERR_ACK. In T+1: cpu_ack=1, cpu_rdata=0, bus_error=1. bus_error_addr takes the address at the request edge.
- cpu_ack and cpu_rdata must never depend combinationally on cpu_request or any cpu_* input (the CPU's request is gated by stall, and stall is derived from ack). They depend only on state registers, ram_rdata, io_ack and io_rdata.
- Back-to-back: a new cpu_request is accepted in any cycle where the state is IDLE or cpu_ack=1. Zero bubble: RAM reads at T and T+1 ack at T+1 and T+2.
- A cpu_request while busy with cpu_ack=0 is a protocol violation. It is ignored, and there is no RAM side-effect (ram_en is gated by the same condition).
- cpu_ack=0 and bus_error=0 in IDLE. Data outputs are don't-care when not acked.
- Reset mid-transaction: abort at the reset edge; io_request=0 the next cycle; no cpu_ack is issued for the aborted access.

Decomposition:
- Shared include header: region-decode constants (IO_REGION default, RAM base) and the state encodings (2-bit) for reuse by the instruction-side bridge.
- No sub-module required. The timeout counter is a 16-bit counter inside the block; the FSM and decode stay in one module.

Test Plan:
1. Write 0x00000010 data 0x12345678 wstrb 1111, then read 0x00000010 -> ram_en at T, ram_addr=4; read acks at T+1 with cpu_rdata=0x12345678; bus_error=0.
2. Reads of 0x0, 0x4, 0x8 on consecutive cycles -> three acks on consecutive cycles with correct data; no bubbles, no dropped requests.
3. Read 0xE0000004, io_ack raised 3 cycles after io_request with io_rdata=0xCAFEF00D -> io_request high exactly 3 cycles plus the ack cycle; cpu_ack coincident with io_ack; cpu_rdata=0xCAFEF00D.
4. TIMEOUT_CYCLES=8, IO write 0xE0000100 with io_ack tied low -> cpu_ack and bus_error together on the 8th IO_WAIT cycle; bus_error_addr=0xE0000100; io_request low the next cycle; a later io_ack is ignored.
5. Write to 0x80000000 -> no ram_en and no io_request; at T+1 cpu_ack=1, cpu_rdata=0, bus_error=1.
6. Assert reset for 1 cycle during IO_WAIT -> io_request=0 the next cycle, no cpu_ack, state IDLE; a following RAM read completes normally.
